// File: rtl/ifetch_align_pkg.sv
// rtl/ifetch_align_pkg.sv - shared constants and types for the RVC-aware fetch/align stage
package ifetch_align_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [1:0]  RVC_FULL_OP = 2'b11;
  localparam int          HW_W        = 16;
  localparam int          BUF_HW      = 3;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DROP = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/ifetch_align_rvc_expander.sv
// rtl/ifetch_align_rvc_expander.sv - RV32C to RV32I expander, used only when RVC_EXPAND_EN is defined
// Illegal, reserved and RV64-only encodings expand to 32'h0000_0000.
module rvc_expander
  import ifetch_align_pkg::*;
(
  input  logic [15:0] c_instr,
  output logic [31:0] instr
);

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {off[12], off[10:5], 5'd0, rs1, f3, off[4:1], off[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p, shamt;
  logic [11:0] imm6, addi4spn_imm, lw_imm, lwsp_imm, swsp_imm, a16sp_imm;
  logic [19:0] lui_imm;
  logic [20:1] j_off;
  logic [12:1] b_off;

  // Immediate fields are scattered across the halfword; gather them once here.
  assign c            = c_instr;
  assign rd           = c[11:7];
  assign rs2          = c[6:2];
  assign rdp          = {2'b01, c[4:2]};
  assign rs1p         = {2'b01, c[9:7]};
  assign shamt        = c[6:2];
  assign imm6         = {{6{c[12]}}, c[12], c[6:2]};
  assign addi4spn_imm = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lw_imm       = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign lwsp_imm     = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign swsp_imm     = {4'b0, c[8:7], c[12:9], 2'b00};
  assign a16sp_imm    = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
  assign lui_imm      = {{14{c[12]}}, c[12], c[6:2]};
  assign j_off        = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
  assign b_off        = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};

  always_comb begin
    instr = '0;
    case ({c[1:0], c[15:13]})
      5'b00_000: if (addi4spn_imm != '0) instr = enc_i(addi4spn_imm, 5'd2, 3'b000, rdp, OPC_OP_IMM);
      5'b00_010: instr = enc_i(lw_imm, rs1p, 3'b010, rdp, OPC_LOAD);
      5'b00_110: instr = enc_s(lw_imm, rdp, rs1p, 3'b010);
      5'b01_000: instr = enc_i(imm6, rd, 3'b000, rd, OPC_OP_IMM);
      5'b01_001: instr = enc_j(j_off, 5'd1);
      5'b01_010: instr = enc_i(imm6, 5'd0, 3'b000, rd, OPC_OP_IMM);
      5'b01_011: begin
        if (rd == 5'd2) begin
          if (a16sp_imm != '0) instr = enc_i(a16sp_imm, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
        end else if ({c[12], c[6:2]} != 6'd0) begin
          instr = {lui_imm, rd, OPC_LUI};
        end
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: if (!c[12]) instr = enc_i({7'b0000000, shamt}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
          2'b01: if (!c[12]) instr = enc_i({7'b0100000, shamt}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
          2'b10: instr = enc_i(imm6, rs1p, 3'b111, rs1p, OPC_OP_IMM);
          default: begin
            if (!c[12]) begin
              case (c[6:5])
                2'b00:   instr = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP);
                2'b01:   instr = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP);
                2'b10:   instr = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP);
                default: instr = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p, OPC_OP);
              endcase
            end
          end
        endcase
      end
      5'b01_101: instr = enc_j(j_off, 5'd0);
      5'b01_110: instr = enc_b(b_off, rs1p, 3'b000);
      5'b01_111: instr = enc_b(b_off, rs1p, 3'b001);
      5'b10_000: if (!c[12]) instr = enc_i({7'b0000000, shamt}, rd, 3'b001, rd, OPC_OP_IMM);
      5'b10_010: if (rd != 5'd0) instr = enc_i(lwsp_imm, 5'd2, 3'b010, rd, OPC_LOAD);
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            if (rd != 5'd0) instr = enc_i(12'd0, rd, 3'b000, 5'd0, OPC_JALR);
          end else begin
            instr = enc_r(7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP);
          end
        end else if (rs2 == 5'd0) begin
          instr = (rd == 5'd0) ? 32'h0010_0073 : enc_i(12'd0, rd, 3'b000, 5'd1, OPC_JALR);
        end else begin
          instr = enc_r(7'b0000000, rs2, rd, 3'b000, rd, OPC_OP);
        end
      end
      5'b10_110: instr = enc_s(swsp_imm, rs2, 5'd2, 3'b010);
      default: instr = '0;
    endcase
  end

endmodule

// File: rtl/ifetch_align.sv
// rtl/ifetch_align.sv - fetch stage realigning 16/32-bit instructions for IF/ID
// Define RVC_EXPAND_EN to expand compressed instructions to RV32I before they leave the stage.
module ifetch_align
  import ifetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        compress_o
);

  logic [BUF_HW-1:0][HW_W-1:0] hb, hb_n;
  logic [1:0]   count, cnt_pop, cnt_n, pop_hw;
  logic [31:0]  head_pc, fetch_addr;
  logic         skip;
  fetch_state_e state;

  logic outstanding, drop, head_compressed, pop, handshake, rsp, push;

  assign outstanding     = (state != IDLE);
  assign drop            = (state == DROP);
  assign head_compressed = (hb[0][1:0] != RVC_FULL_OP);
  assign valid_o         = ((count != 2'd0) && head_compressed) || (count >= 2'd2);
  assign pop             = valid_o && !stall_i && !redirect_i;
  assign pop_hw          = head_compressed ? 2'd1 : 2'd2;

  // Requesting only at count<=1 guarantees a full word always fits after any pop.
  assign imem_req_o  = !rst && !redirect_i && !outstanding && (count <= 2'd1);
  assign imem_addr_o = fetch_addr;
  assign handshake   = imem_req_o && imem_ready_i;
  assign rsp         = imem_rvalid_i && outstanding;
  assign push        = rsp && !drop && !redirect_i;

  always_comb begin
    hb_n    = hb;
    cnt_pop = count;
    if (pop) begin
      if (head_compressed) begin
        hb_n[0] = hb[1];
        hb_n[1] = hb[2];
      end else begin
        hb_n[0] = hb[2];
      end
      cnt_pop = count - pop_hw;
    end
    cnt_n = cnt_pop;
    if (push) begin
      for (int i = 0; i < BUF_HW; i++) begin
        if (skip) begin
          if (i == int'(cnt_pop)) hb_n[i] = imem_rdata_i[31:16];
        end else if (i == int'(cnt_pop)) begin
          hb_n[i] = imem_rdata_i[15:0];
        end else if (i == int'(cnt_pop) + 1) begin
          hb_n[i] = imem_rdata_i[31:16];
        end
      end
      cnt_n = cnt_pop + (skip ? 2'd1 : 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hb         <= '0;
      count      <= 2'd0;
      state      <= IDLE;
      fetch_addr <= RESET_PC & ~32'h3;
      head_pc    <= RESET_PC;
      skip       <= RESET_PC[1];
    end else if (redirect_i) begin
      count      <= 2'd0;
      head_pc    <= redirect_pc_i & ~32'h1;
      fetch_addr <= redirect_pc_i & ~32'h3;
      skip       <= redirect_pc_i[1];
      // A reply landing in this same cycle closes the old request; only a later one is stale.
      state      <= (outstanding && !imem_rvalid_i) ? DROP : IDLE;
    end else begin
      hb    <= hb_n;
      count <= cnt_n;
      if (pop) head_pc <= head_pc + (head_compressed ? 32'd2 : 32'd4);
      if (handshake) fetch_addr <= fetch_addr + 32'd4;
      if (push && skip) skip <= 1'b0;
      case (state)
        IDLE:    if (handshake) state <= WAIT;
        WAIT:    if (imem_rvalid_i) state <= IDLE;
        DROP:    if (imem_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] c_instr;
`ifdef RVC_EXPAND_EN
  rvc_expander u_rvc_expander (
    .c_instr (hb[0]),
    .instr   (c_instr)
  );
`else
  assign c_instr = {16'h0000, hb[0]};
`endif

  assign instr_o    = !valid_o ? NOP_INSTR : (head_compressed ? c_instr : {hb[1], hb[0]});
  assign compress_o = valid_o && head_compressed;
  assign pc_o       = head_pc;

endmodule

// File: tb/tb_ifetch_align.sv
// tb/tb_ifetch_align.sv - directed self-checking bench for ifetch_align
module tb_ifetch_align;

`ifdef RVC_EXPAND_EN
  localparam bit EXP = 1'b1;
`else
  localparam bit EXP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect_i, stall_i, imem_ready_i, imem_rvalid_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, valid_o, compress_o;
  logic [31:0] imem_addr_o, instr_o, pc_o;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  ifetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .compress_o    (compress_o)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return NOP;
  endfunction

  function automatic logic [31:0] c_exp(input logic [15:0] hw, input logic [31:0] full);
    return EXP ? full : {16'h0000, hw};
  endfunction

  // Memory: accepts a request, answers mem_lat cycles after the minimum one-cycle latency.
  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0; paddr = '0; cnt = 0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid_i = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_rd(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if (imem_req_o && imem_ready_i) begin
        pend = 1'b1; paddr = imem_addr_o; cnt = mem_lat;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; redirect_i = 1'b0; stall_i = 1'b0; mem_lat = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_instr(input string name, input logic [31:0] pc,
                              input logic [31:0] ins, input logic comp);
    int n;
    n = 0;
    checks++;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 30);
    if (!valid_o) begin
      errors++;
      $display("FAIL %s timeout: valid_o still 0 after %0d cycles, required 1", name, n);
      return;
    end
    checks++;
    if (pc_o !== pc) begin errors++; $display("FAIL %s pc: got %h want %h", name, pc_o, pc); end
    checks++;
    if (instr_o !== ins) begin errors++; $display("FAIL %s instr: got %h want %h", name, instr_o, ins); end
    checks++;
    if (compress_o !== comp) begin errors++; $display("FAIL %s compress: got %b want %b", name, compress_o, comp); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", valid_o); end
    checks++; if (instr_o !== NOP) begin errors++; $display("FAIL reset instr: got %h want %h", instr_o, NOP); end
    checks++; if (compress_o !== 1'b0) begin errors++; $display("FAIL reset compress: got %b want 0", compress_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset req: got %b want 0", imem_req_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset pc: got %h want 0", pc_o); end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset first req: got req=%b addr=%h want 1/00000000", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_straight();
    mem[32'h0] = 32'h00A0_0093;
    mem[32'h4] = 32'h0010_0113;
    do_reset();
    expect_instr("straight0", 32'h0, 32'h00A0_0093, 1'b0);
    expect_instr("straight4", 32'h4, 32'h0010_0113, 1'b0);
  endtask

  task automatic test_straddle();
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h4585_00A0;
    mem[32'h8] = 32'h0010_0113;
    do_reset();
    expect_instr("straddle_c0", 32'h0, c_exp(16'h4505, 32'h0010_0513), 1'b1);
    expect_instr("straddle_w2", 32'h2, 32'h00A0_0093, 1'b0);
    expect_instr("straddle_c6", 32'h6, c_exp(16'h4585, 32'h0010_0593), 1'b1);
    expect_instr("straddle_w8", 32'h8, 32'h0010_0113, 1'b0);
  endtask

  task automatic test_redirect();
    mem[32'h100] = 32'h4505_1234;
    mem[32'h104] = 32'h0010_0113;
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir req_in_cycle: got %b want 0", imem_req_o); end
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL redir first req: got req=%b addr=%h want 1/00000100", imem_req_o, imem_addr_o);
    end
    expect_instr("redir_102", 32'h102, c_exp(16'h4505, 32'h0010_0513), 1'b1);
    expect_instr("redir_104", 32'h104, 32'h0010_0113, 1'b0);
  endtask

  task automatic test_redirect_outstanding();
    logic seen_req, got;
    mem[32'h0]   = 32'h00A0_0093;
    mem[32'h200] = 32'h0010_0113;
    do_reset();
    mem_lat = 3;
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir_out req_in_cycle: got %b want 0", imem_req_o); end
    @(negedge clk);
    redirect_i = 1'b0;
    seen_req = 1'b0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (valid_o) begin
        got = 1'b1;
      end else if (imem_req_o && !seen_req) begin
        seen_req = 1'b1;
        checks++;
        if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL redir_out addr: got %h want 00000200", imem_addr_o); end
      end
    end
    checks++; if (seen_req !== 1'b1) begin errors++; $display("FAIL redir_out no_req: got %b want 1", seen_req); end
    checks++;
    if (!got) begin
      errors++; $display("FAIL redir_out timeout: valid_o never 1, required 1");
    end else begin
      checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL redir_out pc: got %h want 00000200", pc_o); end
      checks++; if (instr_o !== 32'h0010_0113) begin errors++; $display("FAIL redir_out instr: got %h want 00100113", instr_o); end
    end
    mem_lat = 0;
  endtask

  task automatic test_stall();
    int n;
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h4585_00A0;
    mem[32'h8] = 32'h0010_0113;
    do_reset();
    expect_instr("stall_c0", 32'h0, c_exp(16'h4505, 32'h0010_0513), 1'b1);
    @(negedge clk);
    stall_i = 1'b1;
    n = 0;
    while (!valid_o && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || pc_o !== 32'h2 || instr_o !== 32'h00A0_0093 || imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL stall hold%0d: got valid=%b pc=%h instr=%h req=%b want 1/00000002/00a00093/0",
                 k, valid_o, pc_o, instr_o, imem_req_o);
      end
    end
    stall_i = 1'b0;
    expect_instr("stall_c6", 32'h6, c_exp(16'h4585, 32'h0010_0593), 1'b1);
    expect_instr("stall_w8", 32'h8, 32'h0010_0113, 1'b0);
  endtask

  task automatic test_reset_pending();
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h4585_00A0;
    do_reset();
    mem_lat = 2;
    expect_instr("rstp_c0", 32'h0, c_exp(16'h4505, 32'h0010_0513), 1'b1);
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rstp req_before: got %b want 1", imem_req_o); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || instr_o !== NOP || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL rstp in_reset: got valid=%b instr=%h req=%b want 0/00000013/0", valid_o, instr_o, imem_req_o);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0; mem_lat = 0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rstp restart: got valid=%b req=%b addr=%h want 0/1/00000000", valid_o, imem_req_o, imem_addr_o);
    end
    expect_instr("rstp_again", 32'h0, c_exp(16'h4505, 32'h0010_0513), 1'b1);
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0; imem_ready_i = 1'b1;
    test_reset();
    test_straight();
    test_straddle();
    test_redirect();
    test_redirect_outstanding();
    test_stall();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
